// File: rtl/seg_mux_display_if.sv
// Control and pin-side signals of the multiplexed seven-segment controller.
// The master drives the display request; the slave (controller) drives the pins.
interface seg_mux_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   disp_val;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      lzb;
    logic [3:0]                bright;
    logic [NUM_DIGITS-1:0]     anode;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic                      frame_done;

    modport master (
        output load, disp_val, digit_en, dp_in, lzb, bright,
        input  anode, seg_out, dp_out, frame_done
    );

    modport slave (
        input  load, disp_val, digit_en, dp_in, lzb, bright,
        output anode, seg_out, dp_out, frame_done
    );
endinterface

// File: rtl/seg_mux_display.sv
// Time-multiplexed common-anode seven-segment controller with hex decode,
// leading-zero blanking, PWM dimming and frame-synchronised value loading.
module seg_mux_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_PERIOD = 100000,
    parameter int CNT_W        = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_mux_display_if.slave bus
);
    localparam int                IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0]  TICK_PRE  = CNT_W'(DIGIT_PERIOD - 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_tick;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [3:0]              r_pwm_cnt;

    logic [4*NUM_DIGITS-1:0] r_act_val,  r_pend_val;
    logic [NUM_DIGITS-1:0]   r_act_en,   r_pend_en;
    logic [NUM_DIGITS-1:0]   r_act_dp,   r_pend_dp;
    logic                    r_pend_flag;

    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_done;

    logic                    w_tick_wrap;
    logic                    w_last_digit;
    logic                    w_boundary;
    logic                    w_pre_boundary;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic [3:0]              w_nib;
    logic                    w_en;
    logic                    w_dp;
    logic                    w_lz_blank;
    logic                    w_on;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign w_tick_wrap    = (r_tick == TICK_LAST);
    assign w_last_digit   = (r_digit_idx == IDX_LAST);
    assign w_boundary     = w_tick_wrap && w_last_digit;
    assign w_pre_boundary = (r_tick == TICK_PRE) && w_last_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick      <= '0;
            r_digit_idx <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (w_tick_wrap) begin
                r_tick      <= '0;
                r_digit_idx <= w_last_digit ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    // Registered one cycle early so the pulse lands on the boundary cycle itself,
    // letting a load seen alongside frame_done take effect at that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_frame_done <= 1'b0;
        else        r_frame_done <= w_pre_boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_val  <= '0;
            r_pend_en   <= '0;
            r_pend_dp   <= '0;
            r_pend_flag <= 1'b0;
            r_act_val   <= '0;
            r_act_en    <= '0;
            r_act_dp    <= '0;
        end else begin
            if (bus.load) begin
                r_pend_val <= bus.disp_val;
                r_pend_en  <= bus.digit_en;
                r_pend_dp  <= bus.dp_in;
            end
            if (w_boundary) begin
                r_pend_flag <= 1'b0;
                if (bus.load) begin
                    r_act_val <= bus.disp_val;
                    r_act_en  <= bus.digit_en;
                    r_act_dp  <= bus.dp_in;
                end else if (r_pend_flag) begin
                    r_act_val <= r_pend_val;
                    r_act_en  <= r_pend_en;
                    r_act_dp  <= r_pend_dp;
                end
            end else if (bus.load) begin
                r_pend_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        w_zero_from = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero_from[i] = ((r_act_val >> (4 * i)) == '0);
        end
    end

    always_comb begin
        w_nib      = 4'h0;
        w_en       = 1'b0;
        w_dp       = 1'b0;
        w_lz_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nib      = r_act_val[4*i +: 4];
                w_en       = r_act_en[i];
                w_dp       = r_act_dp[i];
                w_lz_blank = bus.lzb && (i > 0) && w_zero_from[i];
            end
        end
    end

    assign w_on = w_en && !w_lz_blank && (r_pwm_cnt <= bus.bright);

    // Blank slots drive everything high so the shared bus never glows faintly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode <= '1;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
        end else if (w_on) begin
            r_anode <= ~(NUM_DIGITS'(1) << r_digit_idx);
            r_seg   <= f_decode(w_nib);
            r_dp    <= ~w_dp;
        end else begin
            r_anode <= '1;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
        end
    end

    assign bus.anode      = r_anode;
    assign bus.seg_out    = r_seg;
    assign bus.dp_out     = r_dp;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_mux_display.sv
// Bench for seg_mux_display: directed scenarios plus random loads, checked
// against a cycle-count based model of scan position, PWM phase and frame loading.
module tb_seg_mux_display;
    localparam int N  = 4;
    localparam int DP = 4;
    localparam int FR = N * DP;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_mux_display_if #(.NUM_DIGITS(N)) ifc ();

    seg_mux_display #(.NUM_DIGITS(N), .DIGIT_PERIOD(DP), .CNT_W(17)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] DEC [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int          t;
    logic [15:0] m_act_val, m_pend_val;
    logic [3:0]  m_act_en, m_pend_en, m_act_dp, m_pend_dp;
    bit          m_flag;
    logic [3:0]  e_anode;
    logic [6:0]  e_seg;
    logic        e_dp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_act_val = '0; m_act_en = '0; m_act_dp = '0;
        m_pend_val = '0; m_pend_en = '0; m_pend_dp = '0;
        m_flag = 1'b0;
        e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    endtask

    // One clock: check the pins, predict the next pins, apply load/boundary rules.
    task automatic cyc();
        int idx, pwm;
        bit on, bnd;
        chk("anode", ifc.anode, e_anode);
        chk("seg_out", ifc.seg_out, e_seg);
        chk("dp_out", ifc.dp_out, e_dp);
        chk("frame_done", ifc.frame_done, (t % FR == FR - 1));
        chk("one_anode", ($countones(~ifc.anode) <= 1), 1);
        idx = (t / DP) % N;
        pwm = t % 16;
        on  = m_act_en[idx] && (pwm <= int'(ifc.bright))
              && !(ifc.lzb && idx > 0 && (m_act_val >> (4 * idx)) == 16'h0);
        e_anode = on ? ~(4'b0001 << idx) : 4'hF;
        e_seg   = on ? DEC[m_act_val[4*idx +: 4]] : 7'h7F;
        e_dp    = on ? ~m_act_dp[idx] : 1'b1;
        bnd = (t % FR == FR - 1);
        if (ifc.load) begin
            m_pend_val = ifc.disp_val; m_pend_en = ifc.digit_en; m_pend_dp = ifc.dp_in;
            if (bnd) begin
                m_act_val = ifc.disp_val; m_act_en = ifc.digit_en; m_act_dp = ifc.dp_in;
                m_flag = 1'b0;
            end else begin
                m_flag = 1'b1;
            end
        end else if (bnd && m_flag) begin
            m_act_val = m_pend_val; m_act_en = m_pend_en; m_act_dp = m_pend_dp;
            m_flag = 1'b0;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dp);
        ifc.load = 1'b1; ifc.disp_val = v; ifc.digit_en = en; ifc.dp_in = dp;
        cyc();
        ifc.load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_anode", ifc.anode, 4'hF);
        chk("rst_seg", ifc.seg_out, 7'h7F);
        chk("rst_dp", ifc.dp_out, 1'b1);
        chk("rst_fd", ifc.frame_done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        ifc.load = 1'b0; ifc.disp_val = '0; ifc.digit_en = '0; ifc.dp_in = '0;
        ifc.lzb = 1'b0; ifc.bright = 4'd15;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        run(5);
        do_load(16'h12AB, 4'hF, 4'h0);
        run(48);

        while (t % FR != 3) cyc();
        do_load(16'h1111, 4'hF, 4'h0);
        run(5);
        do_load(16'h2222, 4'hF, 4'h0);
        run(40);

        while (t % FR != FR - 1) cyc();
        ifc.lzb = 1'b1;
        do_load(16'h0000, 4'hF, 4'h0);
        run(32);
        ifc.lzb = 1'b0;

        ifc.bright = 4'd3;
        do_load(16'h12AB, 4'hF, 4'h0);
        run(48);
        ifc.bright = 4'd15;

        do_load(16'h5678, 4'b1011, 4'b0100);
        run(40);

        run(6);
        do_reset();
        run(40);

        for (int i = 0; i < 400; i++) begin
            if ($urandom % 16 == 0) ifc.lzb = 1'($urandom % 2);
            if ($urandom % 16 == 0) ifc.bright = 4'($urandom % 16);
            if (i == 200) do_reset();
            if ($urandom % 8 == 0) do_load(rand_val(), 4'($urandom % 16), 4'($urandom % 16));
            else cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
